// File: rtl/llc_input_arbiter_n_if.sv
// Request/grant bundle between the LLC input queues, the input arbiter and the lookup stage.
// master = queue/replay side driving requests; slave = arbiter.
interface llc_input_arbiter_n_if #(
    parameter int NUM_CH      = 4,
    parameter int LINE_ADDR_W = 26,
    parameter int SET_W       = 8,
    parameter int RQ_DEPTH    = 2
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAG_W = LINE_ADDR_W - SET_W;
    localparam int CNT_W = $clog2(RQ_DEPTH) + 1;

    logic                          decode_en;
    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH*LINE_ADDR_W-1:0] ch_addr;
    logic [NUM_CH-1:0]             ch_hi;
    logic [NUM_CH-1:0]             ch_block;
    logic                          rq_push;
    logic [LINE_ADDR_W-1:0]        rq_push_addr;
    logic [CH_W-1:0]               rq_push_ch;
    logic                          rq_block;

    logic [NUM_CH-1:0]             ch_get;
    logic                          rq_pop;
    logic                          grant_valid;
    logic [CH_W-1:0]               grant_ch;
    logic                          grant_replay;
    logic                          grant_starved;
    logic [SET_W-1:0]              set_next;
    logic [SET_W-1:0]              set;
    logic [TAG_W-1:0]              tag;
    logic [CNT_W-1:0]              rq_count;
    logic                          rq_full;
    logic                          rq_overflow;
    logic                          idle;

    modport master (
        output decode_en, ch_valid, ch_addr, ch_hi, ch_block,
               rq_push, rq_push_addr, rq_push_ch, rq_block,
        input  ch_get, rq_pop, grant_valid, grant_ch, grant_replay, grant_starved,
               set_next, set, tag, rq_count, rq_full, rq_overflow, idle
    );

    modport slave (
        input  decode_en, ch_valid, ch_addr, ch_hi, ch_block,
               rq_push, rq_push_addr, rq_push_ch, rq_block,
        output ch_get, rq_pop, grant_valid, grant_ch, grant_replay, grant_starved,
               set_next, set, tag, rq_count, rq_full, rq_overflow, idle
    );
endinterface

// File: rtl/llc_input_arbiter_n.sv
// LLC input arbiter: replay > starved low > high RR > low RR; grant registered 1 cycle after decode_en.
// Pops (ch_get/rq_pop) are combinational with decode_en; replay pushes into a full queue are dropped.
module llc_input_arbiter_n #(
    parameter int NUM_CH      = 4,
    parameter int LINE_ADDR_W = 26,
    parameter int SET_W       = 8,
    parameter int STARVE_MAX  = 15,
    parameter int RQ_DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    llc_input_arbiter_n_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAG_W = LINE_ADDR_W - SET_W;
    localparam int RQ_AW = $clog2(RQ_DEPTH);
    localparam int CNT_W = RQ_AW + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {SRC_NONE, SRC_RQ, SRC_STARVE, SRC_HI, SRC_LO} src_e;

    logic [CH_W-1:0]        r_ptr_hi, r_ptr_lo;
    logic [ST_W-1:0]        r_starve [NUM_CH];
    logic [LINE_ADDR_W-1:0] r_rq_addr [RQ_DEPTH];
    logic [CH_W-1:0]        r_rq_ch [RQ_DEPTH];
    logic [RQ_AW-1:0]       r_rq_rd, r_rq_wr;
    logic [CNT_W-1:0]       r_rq_count;
    logic                   r_rq_overflow;
    logic                   r_grant_valid, r_grant_replay, r_grant_starved;
    logic [CH_W-1:0]        r_grant_ch;
    logic [SET_W-1:0]       r_set;
    logic [TAG_W-1:0]       r_tag;

    logic [NUM_CH-1:0]      w_elig, w_hi_elig, w_lo_elig;
    logic                   w_rq_elig, w_rq_full, w_rq_push_ok, w_ch_win;
    logic                   w_st_found;
    logic [CH_W-1:0]        w_st_ch, w_win_ch, w_ptr_next;
    logic [CH_W:0]          w_hi_pick, w_lo_pick;
    logic [LINE_ADDR_W-1:0] w_win_addr;
    logic [LINE_ADDR_W-1:0] w_ch_addr [NUM_CH];
    src_e                   w_src;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_addr
        assign w_ch_addr[g] = bus.ch_addr[g*LINE_ADDR_W +: LINE_ADDR_W];
    end

    // Returns {found, index}; search begins at ptr and wraps past NUM_CH-1.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   ptr);
        logic            found;
        logic [CH_W-1:0] idx, cand;
        int              j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            cand = CH_W'(j);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign w_elig    = bus.ch_valid & ~bus.ch_block;
    assign w_hi_elig = w_elig & bus.ch_hi;
    assign w_lo_elig = w_elig & ~bus.ch_hi;
    assign w_rq_elig = (r_rq_count != '0) && !bus.rq_block;
    assign w_hi_pick = rr_pick(w_hi_elig, r_ptr_hi);
    assign w_lo_pick = rr_pick(w_lo_elig, r_ptr_lo);

    always_comb begin
        w_st_found = 1'b0;
        w_st_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_lo_elig[i] && r_starve[i] == ST_W'(STARVE_MAX)) begin
                w_st_found = 1'b1;
                w_st_ch    = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_src      = SRC_NONE;
        w_win_ch   = '0;
        w_win_addr = '0;
        if (bus.decode_en) begin
            if (w_rq_elig) begin
                w_src      = SRC_RQ;
                w_win_ch   = r_rq_ch[r_rq_rd];
                w_win_addr = r_rq_addr[r_rq_rd];
            end else if (w_st_found) begin
                w_src      = SRC_STARVE;
                w_win_ch   = w_st_ch;
                w_win_addr = w_ch_addr[w_st_ch];
            end else if (w_hi_pick[CH_W]) begin
                w_src      = SRC_HI;
                w_win_ch   = w_hi_pick[CH_W-1:0];
                w_win_addr = w_ch_addr[w_hi_pick[CH_W-1:0]];
            end else if (w_lo_pick[CH_W]) begin
                w_src      = SRC_LO;
                w_win_ch   = w_lo_pick[CH_W-1:0];
                w_win_addr = w_ch_addr[w_lo_pick[CH_W-1:0]];
            end
        end
    end

    assign w_ch_win     = (w_src == SRC_STARVE) || (w_src == SRC_HI) || (w_src == SRC_LO);
    assign w_ptr_next   = (w_win_ch == CH_W'(NUM_CH - 1)) ? '0 : w_win_ch + 1'b1;
    assign w_rq_full    = (r_rq_count == CNT_W'(RQ_DEPTH));
    assign w_rq_push_ok = bus.rq_push && (!w_rq_full || bus.rq_pop);

    assign bus.ch_get   = w_ch_win ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_win_ch) : '0;
    assign bus.rq_pop   = (w_src == SRC_RQ);
    assign bus.set_next = (w_src != SRC_NONE) ? w_win_addr[SET_W-1:0] : '0;
    assign bus.idle     = bus.decode_en && (w_src == SRC_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_valid   <= 1'b0;
            r_grant_replay  <= 1'b0;
            r_grant_starved <= 1'b0;
            r_grant_ch      <= '0;
            r_set           <= '0;
            r_tag           <= '0;
            r_ptr_hi        <= '0;
            r_ptr_lo        <= '0;
            for (int i = 0; i < NUM_CH; i++) r_starve[i] <= '0;
        end else if (bus.decode_en) begin
            r_grant_valid <= (w_src != SRC_NONE);
            if (w_src != SRC_NONE) begin
                r_grant_ch      <= w_win_ch;
                r_grant_replay  <= (w_src == SRC_RQ);
                r_grant_starved <= (w_src == SRC_STARVE);
                r_set           <= w_win_addr[SET_W-1:0];
                r_tag           <= w_win_addr[LINE_ADDR_W-1:SET_W];
            end else begin
                r_grant_replay  <= 1'b0;
                r_grant_starved <= 1'b0;
            end
            if (w_src == SRC_HI) r_ptr_hi <= w_ptr_next;
            if (w_src == SRC_STARVE || w_src == SRC_LO) r_ptr_lo <= w_ptr_next;
            // High-class channels never accumulate wait time.
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_lo_elig[i] && !(w_ch_win && w_win_ch == CH_W'(i))) begin
                    if (r_starve[i] != ST_W'(STARVE_MAX)) r_starve[i] <= r_starve[i] + 1'b1;
                end else begin
                    r_starve[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rq_rd       <= '0;
            r_rq_wr       <= '0;
            r_rq_count    <= '0;
            r_rq_overflow <= 1'b0;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                r_rq_addr[i] <= '0;
                r_rq_ch[i]   <= '0;
            end
        end else begin
            if (w_rq_push_ok) begin
                r_rq_addr[r_rq_wr] <= bus.rq_push_addr;
                r_rq_ch[r_rq_wr]   <= bus.rq_push_ch;
                r_rq_wr            <= r_rq_wr + 1'b1;
            end else if (bus.rq_push) begin
                r_rq_overflow <= 1'b1;
            end
            if (bus.rq_pop) r_rq_rd <= r_rq_rd + 1'b1;
            if (w_rq_push_ok && !bus.rq_pop)      r_rq_count <= r_rq_count + 1'b1;
            else if (!w_rq_push_ok && bus.rq_pop) r_rq_count <= r_rq_count - 1'b1;
        end
    end

    assign bus.grant_valid   = r_grant_valid;
    assign bus.grant_ch      = r_grant_ch;
    assign bus.grant_replay  = r_grant_replay;
    assign bus.grant_starved = r_grant_starved;
    assign bus.set           = r_set;
    assign bus.tag           = r_tag;
    assign bus.rq_count      = r_rq_count;
    assign bus.rq_full       = w_rq_full;
    assign bus.rq_overflow   = r_rq_overflow;
endmodule

// File: tb/tb_llc_input_arbiter_n.sv
// Bench for llc_input_arbiter_n: directed scenarios plus randomized traffic against a queue-based model.
module tb_llc_input_arbiter_n;
    localparam int NUM_CH = 4, LINE_ADDR_W = 26, SET_W = 8, STARVE_MAX = 15, RQ_DEPTH = 2;
    localparam int TAG_W = LINE_ADDR_W - SET_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llc_input_arbiter_n_if #(.NUM_CH(NUM_CH), .LINE_ADDR_W(LINE_ADDR_W), .SET_W(SET_W),
                             .RQ_DEPTH(RQ_DEPTH)) bus ();

    llc_input_arbiter_n #(.NUM_CH(NUM_CH), .LINE_ADDR_W(LINE_ADDR_W), .SET_W(SET_W),
                          .STARVE_MAX(STARVE_MAX), .RQ_DEPTH(RQ_DEPTH))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [LINE_ADDR_W-1:0] addr;
        int                     ch;
    } rq_ent_t;

    rq_ent_t                mq[$];
    int                     m_ptr_hi, m_ptr_lo;
    int                     m_starve[NUM_CH];
    logic                   m_gv, m_grep, m_gst, m_ovf;
    logic [1:0]             m_gch;
    logic [SET_W-1:0]       m_set;
    logic [TAG_W-1:0]       m_tag;
    int                     e_kind, e_ch;   // kind: 0 none, 1 replay, 2 starved, 3 high, 4 low
    logic [LINE_ADDR_W-1:0] e_addr;
    logic [NUM_CH-1:0]      c_get;
    logic                   c_pop, c_idle;
    logic [SET_W-1:0]       c_setn;

    task automatic model_reset();
        mq.delete();
        m_ptr_hi = 0; m_ptr_lo = 0;
        for (int i = 0; i < NUM_CH; i++) m_starve[i] = 0;
        m_gv = 0; m_grep = 0; m_gst = 0; m_ovf = 0; m_gch = 0; m_set = 0; m_tag = 0;
    endtask

    function automatic bit elig(int i);
        return bus.ch_valid[i] && !bus.ch_block[i];
    endfunction

    task automatic model_eval();
        int i;
        e_kind = 0; e_ch = 0; e_addr = '0;
        if (bus.decode_en) begin
            if (mq.size() > 0 && !bus.rq_block) begin
                e_kind = 1; e_ch = mq[0].ch; e_addr = mq[0].addr;
            end else begin
                for (int n = 0; n < NUM_CH; n++)
                    if (e_kind == 0 && elig(n) && !bus.ch_hi[n] && m_starve[n] == STARVE_MAX) begin
                        e_kind = 2; e_ch = n;
                    end
                for (int k = 0; k < NUM_CH; k++) begin
                    i = (m_ptr_hi + k) % NUM_CH;
                    if (e_kind == 0 && elig(i) && bus.ch_hi[i]) begin e_kind = 3; e_ch = i; end
                end
                for (int k = 0; k < NUM_CH; k++) begin
                    i = (m_ptr_lo + k) % NUM_CH;
                    if (e_kind == 0 && elig(i) && !bus.ch_hi[i]) begin e_kind = 4; e_ch = i; end
                end
                if (e_kind != 0) e_addr = bus.ch_addr[e_ch*LINE_ADDR_W +: LINE_ADDR_W];
            end
        end
    endtask

    task automatic model_commit();
        rq_ent_t ent;
        if (bus.decode_en) begin
            m_gv = (e_kind != 0);
            if (e_kind != 0) begin
                m_gch = e_ch[1:0]; m_grep = (e_kind == 1); m_gst = (e_kind == 2);
                m_set = e_addr[SET_W-1:0]; m_tag = e_addr[LINE_ADDR_W-1:SET_W];
            end else begin
                m_grep = 0; m_gst = 0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!bus.ch_hi[i] && elig(i) && !(e_kind >= 2 && e_ch == i))
                    m_starve[i] = (m_starve[i] < STARVE_MAX) ? m_starve[i] + 1 : STARVE_MAX;
                else
                    m_starve[i] = 0;
            end
            if (e_kind == 3) m_ptr_hi = (e_ch + 1) % NUM_CH;
            if (e_kind == 2 || e_kind == 4) m_ptr_lo = (e_ch + 1) % NUM_CH;
            if (e_kind == 1) void'(mq.pop_front());
        end
        if (bus.rq_push) begin
            if (mq.size() < RQ_DEPTH) begin
                ent.addr = bus.rq_push_addr; ent.ch = int'(bus.rq_push_ch);
                mq.push_back(ent);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic clear_inputs();
        bus.decode_en = 0; bus.ch_valid = '0; bus.ch_addr = '0; bus.ch_hi = '0;
        bus.ch_block = '0; bus.rq_push = 0; bus.rq_push_addr = '0; bus.rq_push_ch = '0;
        bus.rq_block = 0;
    endtask

    task automatic set_addr(int ch, logic [LINE_ADDR_W-1:0] a);
        bus.ch_addr[ch*LINE_ADDR_W +: LINE_ADDR_W] = a;
    endtask

    task automatic push(logic [LINE_ADDR_W-1:0] a, logic [1:0] ch);
        bus.rq_push = 1; bus.rq_push_addr = a; bus.rq_push_ch = ch;
    endtask

    // Entered and left at a falling edge; inputs set by the caller apply to the next rising edge.
    task automatic cycle();
        #1;
        model_eval();
        c_get = bus.ch_get; c_pop = bus.rq_pop; c_idle = bus.idle; c_setn = bus.set_next;
        @(posedge clk);
        model_commit();
        #1;
        bus.rq_push = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [40:0] regs;
        do_reset();
        bus.ch_valid = 4'b0001; set_addr(0, 26'h0ABCDEF); bus.decode_en = 1;
        push(26'h0000123, 2'd1);
        cycle();
        #2 rst = 1;
        #1;
        regs = {bus.grant_valid, bus.grant_ch, bus.grant_replay, bus.grant_starved,
                bus.set, bus.tag, bus.rq_count, bus.rq_overflow, bus.rq_full};
        total++;
        if (regs !== '0) begin bad++; $display("FAIL reset_async_regs got=%h exp=0", regs); end
        clear_inputs();
        @(negedge clk);
        rst = 0;
        model_reset();
        bus.decode_en = 1;
        cycle();
        total++;
        if ({c_idle, c_get, c_pop, c_setn} !== {1'b1, 13'h0}) begin
            bad++; $display("FAIL reset_idle_comb got=%h exp=%h", {c_idle, c_get, c_pop, c_setn}, {1'b1, 13'h0});
        end
        total++;
        if ({bus.grant_valid, bus.set, bus.tag, bus.rq_count} !== '0) begin
            bad++; $display("FAIL reset_idle_regs gv=%b set=%h tag=%h cnt=%0d exp all 0",
                            bus.grant_valid, bus.set, bus.tag, bus.rq_count);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch;
        logic [3:0] exp_get;
        do_reset();
        bus.ch_hi = 4'b0011; bus.ch_valid = 4'b0011; bus.decode_en = 1;
        set_addr(0, 26'h0000010); set_addr(1, 26'h0000021);
        for (int n = 0; n < 4; n++) begin
            cycle();
            exp_ch = (n % 2 == 0) ? 2'd0 : 2'd1;
            exp_get = 4'b0001 << exp_ch;
            total++;
            if (bus.grant_ch !== exp_ch || bus.grant_valid !== 1'b1) begin
                bad++; $display("FAIL rr_grant_%0d got ch=%0d gv=%b exp ch=%0d gv=1", n, bus.grant_ch, bus.grant_valid, exp_ch);
            end
            total++;
            if (c_get !== exp_get) begin
                bad++; $display("FAIL rr_ch_get_%0d got=%b exp=%b", n, c_get, exp_get);
            end
        end
    endtask

    task automatic test_starvation();
        logic [2:0] got, exp;
        int errs;
        do_reset();
        bus.ch_hi = 4'b0001; bus.ch_valid = 4'b0101; bus.decode_en = 1;
        for (int n = 0; n < 17; n++) begin
            cycle();
            exp = (n == 15) ? {2'd2, 1'b1} : {2'd0, 1'b0};
            got = {bus.grant_ch, bus.grant_starved};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL starve_seq_%0d got ch=%0d st=%b exp ch=%0d st=%b", n, got[2:1], got[0], exp[2:1], exp[0]);
            end
        end
    endtask

    task automatic test_replay();
        do_reset();
        bus.ch_valid = 4'b0001; set_addr(0, 26'h0000AAA);
        push(26'h0001234, 2'd3); cycle();
        push(26'h0005678, 2'd1); cycle();
        total++;
        if (bus.rq_count !== 2'd2) begin bad++; $display("FAIL replay_count got=%0d exp=2", bus.rq_count); end
        bus.decode_en = 1;
        cycle();
        total++;
        if ({c_pop, c_get, bus.grant_replay, bus.grant_ch, bus.set, bus.tag} !== {1'b1, 4'b0, 1'b1, 2'd3, 8'h34, 18'h00012}) begin
            bad++; $display("FAIL replay_first got pop=%b get=%b rep=%b ch=%0d set=%h tag=%h exp 1 0000 1 3 34 00012",
                            c_pop, c_get, bus.grant_replay, bus.grant_ch, bus.set, bus.tag);
        end
        cycle();
        total++;
        if ({bus.grant_replay, bus.grant_ch, bus.set, bus.tag} !== {1'b1, 2'd1, 8'h78, 18'h00056}) begin
            bad++; $display("FAIL replay_second got rep=%b ch=%0d set=%h tag=%h exp 1 1 78 00056",
                            bus.grant_replay, bus.grant_ch, bus.set, bus.tag);
        end
        cycle();
        total++;
        if ({bus.grant_replay, bus.grant_ch, bus.set, bus.tag, c_get} !== {1'b0, 2'd0, 8'hAA, 18'h0000A, 4'b0001}) begin
            bad++; $display("FAIL replay_then_ch0 got rep=%b ch=%0d set=%h tag=%h get=%b exp 0 0 aa 0000a 0001",
                            bus.grant_replay, bus.grant_ch, bus.set, bus.tag, c_get);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push(26'h0000111, 2'd0); cycle();
        push(26'h0000222, 2'd1); cycle();
        push(26'h0000333, 2'd2); cycle();
        total++;
        if ({bus.rq_count, bus.rq_full, bus.rq_overflow} !== {2'd2, 1'b1, 1'b1}) begin
            bad++; $display("FAIL ovf_state got cnt=%0d full=%b ovf=%b exp 2 1 1", bus.rq_count, bus.rq_full, bus.rq_overflow);
        end
        bus.decode_en = 1;
        push(26'h0000444, 2'd3);
        cycle();
        total++;
        if ({c_pop, bus.set, bus.rq_count, bus.rq_full} !== {1'b1, 8'h11, 2'd2, 1'b1}) begin
            bad++; $display("FAIL ovf_push_pop_full got pop=%b set=%h cnt=%0d full=%b exp 1 11 2 1", c_pop, bus.set, bus.rq_count, bus.rq_full);
        end
        cycle();
        cycle();
        total++;
        if ({bus.grant_ch, bus.set, bus.rq_count} !== {2'd3, 8'h44, 2'd0}) begin
            bad++; $display("FAIL ovf_drain got ch=%0d set=%h cnt=%0d exp 3 44 0", bus.grant_ch, bus.set, bus.rq_count);
        end
        cycle();
        total++;
        if ({c_idle, bus.grant_valid, bus.rq_overflow} !== 3'b101) begin
            bad++; $display("FAIL ovf_dropped_never got idle=%b gv=%b ovf=%b exp 1 0 1", c_idle, bus.grant_valid, bus.rq_overflow);
        end
    endtask

    task automatic test_block_hold();
        do_reset();
        push(26'h0000999, 2'd2); cycle();
        bus.rq_block = 1; bus.ch_valid = 4'b0010; set_addr(1, 26'h0BEEF55); bus.decode_en = 1;
        cycle();
        total++;
        if ({c_pop, c_get, bus.grant_replay, bus.grant_ch} !== {1'b0, 4'b0010, 1'b0, 2'd1}) begin
            bad++; $display("FAIL block_rq got pop=%b get=%b rep=%b ch=%0d exp 0 0010 0 1", c_pop, c_get, bus.grant_replay, bus.grant_ch);
        end
        bus.decode_en = 0; bus.rq_block = 0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            total++;
            if ({c_get, c_pop, c_idle, bus.grant_valid, bus.grant_ch, bus.set, bus.tag, bus.rq_count}
                !== {4'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h55, 18'h0BEEF, 2'd1}) begin
                bad++; $display("FAIL hold_%0d got get=%b pop=%b idle=%b gv=%b ch=%0d set=%h tag=%h cnt=%0d exp 0 0 0 1 1 55 0beef 1",
                                n, c_get, c_pop, c_idle, bus.grant_valid, bus.grant_ch, bus.set, bus.tag, bus.rq_count);
            end
        end
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] e_get;
        logic [13:0]       got_c, exp_c;
        logic [32:0]       got_r, exp_r;
        do_reset();
        bus.ch_hi = 4'($urandom);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) bus.ch_hi = 4'($urandom);
            bus.decode_en = ($urandom_range(0, 9) < 8);
            bus.ch_valid  = 4'($urandom | $urandom);
            bus.ch_block  = 4'($urandom & $urandom & $urandom);
            bus.rq_block  = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < NUM_CH; c++) set_addr(c, 26'($urandom));
            if ($urandom_range(0, 5) == 0) push(26'($urandom), 2'($urandom));
            cycle();
            e_get = (e_kind >= 2) ? (4'b0001 << e_ch) : 4'b0;
            exp_c = {e_get, 1'(e_kind == 1), 1'(bus.decode_en && e_kind == 0),
                     (e_kind != 0) ? e_addr[SET_W-1:0] : 8'h00};
            got_c = {c_get, c_pop, c_idle, c_setn};
            total++;
            if (got_c !== exp_c) begin
                bad++; $display("FAIL rand_comb_%0d got get/pop/idle/setn=%h exp=%h", n, got_c, exp_c);
            end
            exp_r = {m_gv, m_gch, m_grep, m_gst, m_set, m_tag, 2'(mq.size()), 1'(mq.size() == RQ_DEPTH), m_ovf};
            got_r = {bus.grant_valid, bus.grant_ch, bus.grant_replay, bus.grant_starved, bus.set, bus.tag,
                     bus.rq_count, bus.rq_full, bus.rq_overflow};
            total++;
            if (got_r !== exp_r) begin
                bad++; $display("FAIL rand_regs_%0d got=%h exp=%h", n, got_r, exp_r);
            end
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();
        test_reset();
        test_round_robin();
        test_starvation();
        test_replay();
        test_overflow();
        test_block_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/llc_input_arbiter_n.md
Name: llc_input_arbiter_n

Overview:
- Parametrised successor of the LLC input decoder.
- Arbitrates NUM_CH incoming request channels plus an internal replay queue of stalled requests, one decision per decode_en cycle.
- Class priority: replay queue, then high-priority class, then low-priority class. Round-robin fairness within each class; starvation preemption for low-class channels.
- Registers the winning channel id and its set/tag breakdown for the LLC lookup stage. Sits between the LLC input queues and the lookup/process pipeline.

Parameters:
- NUM_CH, 4, number of request channels (2..8).
- LINE_ADDR_W, 26, line address width.
- SET_W, 8, set index width; TAG_W = LINE_ADDR_W - SET_W.
- STARVE_MAX, 15, wait cycles before a low-class channel preempts the high class.
- RQ_DEPTH, 2, replay queue depth (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- decode_en  in  1  arbitration/update strobe
- ch_valid  in  NUM_CH  channel has a request
- ch_addr  in  NUM_CH*LINE_ADDR_W  channel line addresses, ch0 in LSBs
- ch_hi  in  NUM_CH  static class mask; 1 = high class
- ch_block  in  NUM_CH  channel temporarily ineligible
- rq_push  in  1  enqueue a stalled request
- rq_push_addr  in  LINE_ADDR_W  stalled address
- rq_push_ch  in  $clog2(NUM_CH)  originating channel
- rq_block  in  1  replay queue ineligible this cycle
- ch_get  out  NUM_CH  one-hot pop of the granted channel, combinational, only when decode_en
- rq_pop  out  1  replay entry consumed, combinational
- grant_valid  out  1  registered: a grant was made at the last decode_en
- grant_ch  out  $clog2(NUM_CH)  registered winning channel (original channel for replay)
- grant_replay  out  1  registered: grant came from replay queue
- grant_starved  out  1  registered: grant was a starvation preemption
- set_next  out  SET_W  combinational set of the current winner, 0 if none
- set  out  SET_W  registered set
- tag  out  TAG_W  registered tag
- rq_count  out  $clog2(RQ_DEPTH)+1  replay occupancy
- rq_full  out  1  rq_count == RQ_DEPTH
- rq_overflow  out  1  sticky: a push was dropped; cleared only by rst
- idle  out  1  combinational: decode_en and nothing eligible

Behaviour:
- Reset (async, rst=1): all registered outputs are 0, both RR pointers are 0, starvation counters are 0, replay queue is empty, rq_overflow is 0.
- Eligibility:
  - Channel i is eligible when ch_valid[i] & ~ch_block[i].
  - Replay is eligible when rq_count != 0 & ~rq_block.
- Priority order at decode_en:
  1. Replay head.
  2. Lowest-index low-class eligible channel with starve_cnt == STARVE_MAX.
  3. High-class round-robin.
  4. Low-class round-robin.
- Round-robin:
  - Search starts at ptr_class and wraps modulo NUM_CH.
  - On a grant, ptr_class becomes (winner+1) mod NUM_CH.
  - A starvation grant also advances the low pointer.
- Starvation counters (low-class channels only, change only on decode_en cycles):
  - Eligible and not granted: increment, saturating at STARVE_MAX.
  - Granted or not eligible: reset to 0.
- Outputs when decode_en=1:
  - Exactly one of ch_get / rq_pop asserts for the winner.
  - grant_*, set and tag load from the winner, with tag = addr[LINE_ADDR_W-1:SET_W] and set = addr[SET_W-1:0].
  - If there is no winner, grant_valid <= 0, set/tag hold their values, and idle=1.
- decode_en=0: no pops, no counter or pointer change, registered outputs hold, idle=0.
- Grant latency: one cycle from decode_en to the registered grant.
- Replay queue is a circular FIFO:
  - rq_push enqueues at the tail regardless of decode_en.
  - Push when full with no same-cycle pop: drop the entry and set rq_overflow.
  - Push and pop in the same cycle when full: accepted, count unchanged.
  - Push and pop in the same cycle when empty: the pushed entry is not visible until the next cycle.
  - Read/write pointers wrap modulo RQ_DEPTH.
- ch_hi changes take effect on the next decode_en; pointers are not reset.

Test Plan:
- Reset/idle: rst=1 mid-grant, then release, decode_en=1, no valids -> all outputs 0, idle=1, rq_count=0.
- Round-robin: NUM_CH=4, ch_hi=4'b0011, ch0 and ch1 valid continuously, 4 decode_en cycles -> grant_ch sequence 0,1,0,1; ch_get one-hot each cycle.
- Starvation: ch_hi=4'b0001, ch0 and ch2 always valid, STARVE_MAX=15 -> ch0 granted 15 times, then ch2 granted with grant_starved=1, then ch0 resumes.
- Replay priority/order: push addr 0x0001234 (ch3) then 0x0005678 (ch1), ch0 valid -> next two grants are replay with grant_ch=3, set=0x34, tag=0x00012, then grant_ch=1, set=0x78, tag=0x00056; then ch0.
- Overflow: RQ_DEPTH=2, three pushes without pops -> rq_count=2, rq_full=1, rq_overflow=1, third address never granted. Push+pop when full -> count stays 2.
- Block/hold: rq_block=1 with queue non-empty and ch1 valid -> ch1 granted. decode_en=0 for 3 cycles -> grant/set/tag unchanged, no ch_get.
